// File: rtl/key_search_engine_pkg.sv
// Shared definitions for the key search engine: FSM encoding, read-map addresses
// and status-word bit positions.
package key_search_engine_pkg;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_NEXTKEY   = 3'd3,
    ST_FOUND     = 3'd4,
    ST_EXHAUSTED = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;

  localparam logic [3:0] ADDR_KEYS_LO = 4'd0;
  localparam logic [3:0] ADDR_KEYS_HI = 4'd1;
  localparam logic [3:0] ADDR_BLK_LO  = 4'd2;
  localparam logic [3:0] ADDR_BLK_HI  = 4'd3;
  localparam logic [3:0] ADDR_STATUS  = 4'd4;
  localparam logic [3:0] ADDR_FKEY_HI = 4'd5;
  localparam logic [3:0] ADDR_FKEY_LO = 4'd6;

  localparam int ST_BIT_LOADED    = 0;
  localparam int ST_BIT_BUSY      = 1;
  localparam int ST_BIT_FOUND     = 2;
  localparam int ST_BIT_EXHAUSTED = 3;
  localparam int ST_BIT_HALTED    = 4;

endpackage

// File: rtl/key_search_engine_if.sv
// Request/response link between the key search engine and the decryption core.
// Request: a transfer happens on a posedge where core_valid && core_ready; while
// core_valid is high and core_ready low, core_key/core_ct hold stable. Response:
// core_pt_valid is a one-cycle strobe qualifying core_pt, with no back-pressure.
interface key_search_engine_if #(
  parameter int KEY_W = 32
) ();
  logic             core_valid;
  logic             core_ready;
  logic [KEY_W-1:0] core_key;
  logic [63:0]      core_ct;
  logic             core_pt_valid;
  logic [63:0]      core_pt;

  modport master (
    output core_valid, core_key, core_ct,
    input  core_ready, core_pt_valid, core_pt
  );

  modport slave (
    input  core_valid, core_key, core_ct,
    output core_ready, core_pt_valid, core_pt
  );
endinterface

// File: rtl/key_search_engine_printable_check.sv
// Flags a 64-bit plaintext block as acceptable when every byte lies in [PT_LO, PT_HI].
module printable_check #(
  parameter logic [7:0] PT_LO = 8'h20,
  parameter logic [7:0] PT_HI = 8'h7E
) (
  input  logic [63:0] data,
  output logic        ok
);

  always_comb begin
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((data[i*8 +: 8] < PT_LO) || (data[i*8 +: 8] > PT_HI)) ok = 1'b0;
    end
  end

endmodule

// File: rtl/key_search_engine.sv
// Captures four ciphertext levels, then sweeps key candidates through an external
// decryption core until all four plaintexts are printable, the key space runs out, or stop.
module key_search_engine
  import key_search_engine_pkg::*;
#(
  parameter int         KEY_W = 32,
  parameter logic [7:0] PT_LO = 8'h20,
  parameter logic [7:0] PT_HI = 8'h7E
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startLC,
  input  logic [63:0]           dataToLC,
  input  logic [2:0]            levels,
  input  logic                  stop,
  input  logic [3:0]            pckeyaddr,
  output logic [15:0]           pckeydata,
  key_search_engine_if.master   core,
  output logic                  found,
  output logic                  busy,
  output state_t                dbg_state
);

  state_t           state_q, state_d;
  logic [63:0]      ct_q [4];
  logic [63:0]      ct_d [4];
  logic [3:0]       load_mask_q, load_mask_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [31:0]      keys_tried_q, keys_tried_d;
  logic [31:0]      blocks_dec_q, blocks_dec_d;
  logic [KEY_W-1:0] found_key_q, found_key_d;
  logic             pt_ok;
  logic [15:0]      status;

  printable_check #(.PT_LO(PT_LO), .PT_HI(PT_HI)) u_printable (
    .data (core.core_pt),
    .ok   (pt_ok)
  );

  always_comb begin
    state_d      = state_q;
    ct_d         = ct_q;
    load_mask_d  = load_mask_q;
    key_d        = key_q;
    lvl_d        = lvl_q;
    keys_tried_d = keys_tried_q;
    blocks_dec_d = blocks_dec_q;
    found_key_d  = found_key_q;

    if (stop) begin
      // A halt discards the loaded ciphertext set; only a reset restarts the engine.
      state_d     = ST_HALTED;
      load_mask_d = 4'h0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (startLC && !levels[2]) begin
            ct_d[levels[1:0]] = dataToLC;
            load_mask_d       = load_mask_q | (4'b0001 << levels[1:0]);
          end
          if (load_mask_d == 4'hF) begin
            state_d = ST_ISSUE;
            key_d   = '0;
            lvl_d   = 2'd0;
          end
        end
        ST_ISSUE: begin
          if (core.core_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (core.core_pt_valid) begin
            blocks_dec_d = (&blocks_dec_q) ? blocks_dec_q : blocks_dec_q + 32'd1;
            if (!pt_ok) begin
              state_d = ST_NEXTKEY;
            end else if (lvl_q == 2'd3) begin
              state_d      = ST_FOUND;
              found_key_d  = key_q;
              keys_tried_d = keys_tried_q + 32'd1;
            end else begin
              lvl_d   = lvl_q + 2'd1;
              state_d = ST_ISSUE;
            end
          end
        end
        ST_NEXTKEY: begin
          keys_tried_d = keys_tried_q + 32'd1;
          if (&key_q) begin
            state_d = ST_EXHAUSTED;
          end else begin
            key_d   = key_q + KEY_W'(1);
            lvl_d   = 2'd0;
            state_d = ST_ISSUE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      for (int i = 0; i < 4; i++) ct_q[i] <= '0;
      load_mask_q  <= 4'h0;
      key_q        <= '0;
      lvl_q        <= 2'd0;
      keys_tried_q <= '0;
      blocks_dec_q <= '0;
      found_key_q  <= '0;
    end else begin
      state_q      <= state_d;
      ct_q         <= ct_d;
      load_mask_q  <= load_mask_d;
      key_q        <= key_d;
      lvl_q        <= lvl_d;
      keys_tried_q <= keys_tried_d;
      blocks_dec_q <= blocks_dec_d;
      found_key_q  <= found_key_d;
    end
  end

  assign core.core_valid = (state_q == ST_ISSUE);
  assign core.core_key   = key_q;
  assign core.core_ct    = ct_q[lvl_q];

  assign found     = (state_q == ST_FOUND);
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_NEXTKEY);
  assign dbg_state = state_q;

  always_comb begin
    status                   = '0;
    status[ST_BIT_LOADED]    = &load_mask_q;
    status[ST_BIT_BUSY]      = busy;
    status[ST_BIT_FOUND]     = found;
    status[ST_BIT_EXHAUSTED] = (state_q == ST_EXHAUSTED);
    status[ST_BIT_HALTED]    = (state_q == ST_HALTED);
  end

  always_comb begin
    pckeydata = '0;
    case (pckeyaddr)
      ADDR_KEYS_LO: pckeydata = keys_tried_q[15:0];
      ADDR_KEYS_HI: pckeydata = keys_tried_q[31:16];
      ADDR_BLK_LO:  pckeydata = blocks_dec_q[15:0];
      ADDR_BLK_HI:  pckeydata = blocks_dec_q[31:16];
      ADDR_STATUS:  pckeydata = status;
      ADDR_FKEY_HI: pckeydata = found_key_q[31:16];
      ADDR_FKEY_LO: pckeydata = found_key_q[15:0];
      default:      pckeydata = '0;
    endcase
  end

endmodule
